oled_bus_decoder: RTL and testbench

OLED_BUS_DECODER -- requirements
Module: oled_bus_decoder

---
 rtl/oled_pkg.sv | 32 +++
 rtl/oled_bus_decoder_if.sv | 12 +
 rtl/oled_bus_decoder.sv | 199 +++++++++++++++++++
 tb/tb_oled_bus_decoder.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/oled_pkg.sv
// Shared definitions for the OLED command bus: opcodes, geometry defaults and
// the per-opcode argument count used by both the initiator and the decoder.
package oled_pkg;

   localparam int unsigned WIDTH_DEF  = 128;
   localparam int unsigned HEIGHT_DEF = 128;
   localparam int unsigned COORD_W    = 7;

   localparam logic [7:0] CMD_SET_COL   = 8'h15;
   localparam logic [7:0] CMD_SET_ROW   = 8'h75;
   localparam logic [7:0] CMD_WRITE_RAM = 8'h5C;
   localparam logic [7:0] CMD_REMAP     = 8'hA0;
   localparam logic [7:0] CMD_DISP_OFF  = 8'hAE;
   localparam logic [7:0] CMD_DISP_ON   = 8'hAF;

   typedef enum logic [1:0] {
      ST_CMD,
      ST_ARG,
      ST_RAM
   } dec_state_t;

   // Number of argument bytes following an opcode; the RAM stream opcode has
   // no fixed count and is recognised separately by the decoder.
   function automatic logic [1:0] cmd_arity(input logic [7:0] op);
      case (op)
         CMD_SET_COL, CMD_SET_ROW, CMD_REMAP, 8'hB4, 8'hD1: return 2'd2;
         CMD_DISP_OFF, CMD_DISP_ON, CMD_WRITE_RAM:         return 2'd0;
         default:                                          return 2'd1;
      endcase
   endfunction

endpackage

// File: rtl/oled_bus_decoder_if.sv
// Parallel OLED host bus: chip select, write strobe, data/command select and byte.
interface oled_bus_decoder_if;

   logic       oled_cs;
   logic       oled_e;
   logic       oled_dc;
   logic [7:0] oled_din;

   modport master (output oled_cs, output oled_e, output oled_dc, output oled_din);
   modport slave  (input  oled_cs, input  oled_e, input  oled_dc, input  oled_din);

endinterface

// File: rtl/oled_bus_decoder.sv
// Decodes the OLED host bus into completed commands, display state and
// RGB565 framebuffer writes addressed by a windowed cursor.
module oled_bus_decoder
   import oled_pkg::*;
#(
   parameter int unsigned WIDTH  = WIDTH_DEF,
   parameter int unsigned HEIGHT = HEIGHT_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   oled_bus_decoder_if.slave     bus,
   output logic                  fb_we,
   output logic [2*COORD_W-1:0]  fb_addr,
   output logic [15:0]           fb_data,
   output logic                  cmd_valid,
   output logic [7:0]            cmd_op,
   output logic                  display_on,
   output logic [7:0]            remap,
   output logic                  proto_err
);

   dec_state_t state, state_n;

   logic               e_q;
   logic [7:0]         op_q;
   logic [1:0]         arg_cnt;
   logic [7:0]         arg0_q;
   logic [7:0]         hi_q;
   logic               half;
   logic [COORD_W-1:0] col_start, col_end, row_start, row_end;
   logic [COORD_W-1:0] col, row;
   logic [COORD_W-1:0] col_lim, row_lim;

   logic       accept;
   logic       new_op, arg_take, done, err;
   logic       pix_hi, pix_wr, ram_enter, drop_half;
   logic [7:0] done_op;

   assign accept = e_q & ~bus.oled_e & ~bus.oled_cs;

   // Effective window ends: clamp to the panel, and collapse an inverted
   // window to a single line at its start.
   always_comb begin
      col_lim = col_end;
      row_lim = row_end;
      if (32'(col_end) >= WIDTH)  col_lim = COORD_W'(WIDTH - 1);
      if (32'(row_end) >= HEIGHT) row_lim = COORD_W'(HEIGHT - 1);
      if (col_start > col_lim) col_lim = col_start;
      if (row_start > row_lim) row_lim = row_start;
   end

   always_comb begin
      state_n   = state;
      new_op    = 1'b0;
      arg_take  = 1'b0;
      done      = 1'b0;
      done_op   = op_q;
      err       = 1'b0;
      pix_hi    = 1'b0;
      pix_wr    = 1'b0;
      ram_enter = 1'b0;
      drop_half = 1'b0;
      if (accept) begin
         case (state)
            ST_CMD: begin
               if (bus.oled_dc) err    = 1'b1;
               else             new_op = 1'b1;
            end
            ST_ARG: begin
               if (bus.oled_dc) begin
                  arg_take = 1'b1;
                  if (arg_cnt == 2'd1) begin
                     done    = 1'b1;
                     state_n = ST_CMD;
                  end
               end else begin
                  err    = 1'b1;
                  new_op = 1'b1;
               end
            end
            ST_RAM: begin
               if (bus.oled_dc) begin
                  if (half) pix_wr = 1'b1;
                  else      pix_hi = 1'b1;
               end else begin
                  err       = half;
                  drop_half = 1'b1;
                  new_op    = 1'b1;
               end
            end
            default: state_n = ST_CMD;
         endcase
      end
      // Any opcode byte, whatever state it interrupted, is decoded here.
      if (new_op) begin
         done_op = bus.oled_din;
         if (bus.oled_din == CMD_WRITE_RAM) begin
            done      = 1'b1;
            ram_enter = 1'b1;
            state_n   = ST_RAM;
         end else if (cmd_arity(bus.oled_din) == 2'd0) begin
            done    = 1'b1;
            state_n = ST_CMD;
         end else begin
            state_n = ST_ARG;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ST_CMD;
      end else begin
         state <= state_n;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         e_q        <= 1'b0;
         op_q       <= '0;
         arg_cnt    <= '0;
         arg0_q     <= '0;
         hi_q       <= '0;
         half       <= 1'b0;
         col_start  <= '0;
         row_start  <= '0;
         col_end    <= COORD_W'(WIDTH - 1);
         row_end    <= COORD_W'(HEIGHT - 1);
         col        <= '0;
         row        <= '0;
         fb_we      <= 1'b0;
         fb_addr    <= '0;
         fb_data    <= '0;
         cmd_valid  <= 1'b0;
         cmd_op     <= '0;
         display_on <= 1'b0;
         remap      <= '0;
         proto_err  <= 1'b0;
      end else begin
         e_q       <= bus.oled_e;
         fb_we     <= pix_wr;
         cmd_valid <= done;
         if (err) proto_err <= 1'b1;

         if (new_op) begin
            op_q    <= bus.oled_din;
            arg_cnt <= cmd_arity(bus.oled_din);
         end
         if (arg_take) begin
            arg_cnt <= arg_cnt - 2'd1;
            if (arg_cnt == 2'd2) arg0_q <= bus.oled_din;
         end

         // Side effects fire on completion; two-argument commands see arg 1 on the bus.
         if (done) begin
            cmd_op <= done_op;
            case (done_op)
               CMD_SET_COL: begin
                  col_start <= arg0_q[COORD_W-1:0];
                  col_end   <= bus.oled_din[COORD_W-1:0];
               end
               CMD_SET_ROW: begin
                  row_start <= arg0_q[COORD_W-1:0];
                  row_end   <= bus.oled_din[COORD_W-1:0];
               end
               CMD_REMAP:    remap      <= arg0_q;
               CMD_DISP_ON:  display_on <= 1'b1;
               CMD_DISP_OFF: display_on <= 1'b0;
               default: ;
            endcase
         end

         if (drop_half) half <= 1'b0;
         if (ram_enter) begin
            col  <= col_start;
            row  <= row_start;
            half <= 1'b0;
         end
         if (pix_hi) begin
            hi_q <= bus.oled_din;
            half <= 1'b1;
         end
         if (pix_wr) begin
            fb_addr <= {row, col};
            fb_data <= {hi_q, bus.oled_din};
            half    <= 1'b0;
            if (col == col_lim) begin
               col <= col_start;
               if (row == row_lim) row <= row_start;
               else                row <= row + 1'b1;
            end else begin
               col <= col + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_oled_bus_decoder.sv
// Directed bench for oled_bus_decoder: a scoreboard of expected framebuffer
// writes and completed opcodes is checked against the DUT output pulses.
module tb_oled_bus_decoder;
   import oled_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   oled_bus_decoder_if bus();

   logic        fb_we, cmd_valid, display_on, proto_err;
   logic [13:0] fb_addr;
   logic [15:0] fb_data;
   logic [7:0]  cmd_op, remap;

   oled_bus_decoder #(.WIDTH(128), .HEIGHT(128)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus),
      .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data),
      .cmd_valid(cmd_valid), .cmd_op(cmd_op), .display_on(display_on),
      .remap(remap), .proto_err(proto_err)
   );

   int tests = 0;
   int fails = 0;

   logic [29:0] wr_q[$];
   logic [7:0]  op_q[$];
   logic [29:0] w_exp;
   logic [7:0]  o_exp;

   logic [6:0] m_cs, m_ce, m_rs, m_re, m_col, m_row;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (fb_we === 1'b1) begin
         if (wr_q.size() == 0) check("unexpected_fb_we", 32'(fb_we), 32'd0);
         else begin
            w_exp = wr_q.pop_front();
            check("fb_addr", 32'(fb_addr), 32'(w_exp[29:16]));
            check("fb_data", 32'(fb_data), 32'(w_exp[15:0]));
         end
      end
      if (cmd_valid === 1'b1) begin
         if (op_q.size() == 0) check("unexpected_cmd_valid", 32'(cmd_valid), 32'd0);
         else begin
            o_exp = op_q.pop_front();
            check("cmd_op", 32'(cmd_op), 32'(o_exp));
         end
      end
      if (fb_we === 1'b1 && cmd_valid === 1'b1) check("we_valid_overlap", 32'(cmd_valid), 32'd0);
   end

   function automatic logic [6:0] lim(input logic [6:0] s, input logic [6:0] e, input int unsigned n);
      logic [6:0] l;
      l = (32'(e) >= n) ? 7'(n - 1) : e;
      if (s > l) l = s;
      return l;
   endfunction

   task automatic adv();
      if (m_col == lim(m_cs, m_ce, 128)) begin
         m_col = m_cs;
         if (m_row == lim(m_rs, m_re, 128)) m_row = m_rs;
         else                                m_row = m_row + 7'd1;
      end else begin
         m_col = m_col + 7'd1;
      end
   endtask

   // Called at a falling edge; returns at the falling edge after the accept edge.
   task automatic send(input logic dc, input logic [7:0] b);
      bus.oled_cs  = 1'b0;
      bus.oled_dc  = dc;
      bus.oled_din = b;
      bus.oled_e   = 1'b1;
      @(negedge clk);
      bus.oled_e   = 1'b0;
      @(negedge clk);
   endtask

   task automatic cs_toggle();
      bus.oled_cs = 1'b1;
      bus.oled_e  = 1'b1;
      @(negedge clk);
      bus.oled_e  = 1'b0;
      @(negedge clk);
   endtask

   task automatic cmd0(input logic [7:0] op);
      op_q.push_back(op);
      send(1'b0, op);
   endtask

   task automatic cmd2(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
      op_q.push_back(op);
      send(1'b0, op);
      send(1'b1, a);
      send(1'b1, b);
      if (op == CMD_SET_COL) begin m_cs = a[6:0]; m_ce = b[6:0]; end
      if (op == CMD_SET_ROW) begin m_rs = a[6:0]; m_re = b[6:0]; end
   endtask

   task automatic ram();
      op_q.push_back(CMD_WRITE_RAM);
      send(1'b0, CMD_WRITE_RAM);
      m_col = m_cs;
      m_row = m_rs;
   endtask

   task automatic pixel(input logic [15:0] d);
      wr_q.push_back({m_row, m_col, d});
      adv();
      send(1'b1, d[15:8]);
      send(1'b1, d[7:0]);
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_fb_we"},      32'(fb_we),      32'd0);
      check({tag, "_cmd_valid"},  32'(cmd_valid),  32'd0);
      check({tag, "_cmd_op"},     32'(cmd_op),     32'd0);
      check({tag, "_display_on"}, 32'(display_on), 32'd0);
      check({tag, "_remap"},      32'(remap),      32'd0);
      check({tag, "_proto_err"},  32'(proto_err),  32'd0);
      check({tag, "_fb_addr"},    32'(fb_addr),    32'd0);
      check({tag, "_fb_data"},    32'(fb_data),    32'd0);
   endtask

   task automatic do_reset();
      rst_n        = 1'b0;
      bus.oled_cs  = 1'b1;
      bus.oled_e   = 1'b0;
      bus.oled_dc  = 1'b0;
      bus.oled_din = 8'h00;
      repeat (2) @(negedge clk);
      check_reset("reset");
      m_cs = 7'd0; m_ce = 7'd127; m_rs = 7'd0; m_re = 7'd127;
      m_col = 7'd0; m_row = 7'd0;
      rst_n = 1'b1;
   endtask

   initial begin
      do_reset();

      // Display on/off
      cmd0(CMD_DISP_ON);
      check("disp_on", 32'(display_on), 32'd1);
      check("disp_on_op", 32'(cmd_op), 32'hAF);
      cmd0(CMD_DISP_OFF);
      check("disp_off", 32'(display_on), 32'd0);

      // Two-column, one-row window
      cmd2(CMD_SET_COL, 8'h10, 8'h11);
      cmd2(CMD_SET_ROW, 8'h20, 8'h20);
      ram();
      repeat (4) pixel(16'hF800);
      check("win_last_addr", 32'(fb_addr), 32'h1011);
      check("win_no_err", 32'(proto_err), 32'd0);
      cmd2(CMD_REMAP, 8'h55, 8'h00);
      check("remap", 32'(remap), 32'h55);

      // Opcode interrupting a half pixel
      ram();
      send(1'b1, 8'hAB);
      cmd0(CMD_DISP_ON);
      check("half_drop_err", 32'(proto_err), 32'd1);
      check("half_drop_disp", 32'(display_on), 32'd1);

      // Chip select released mid-pixel and mid-command
      ram();
      wr_q.push_back({m_row, m_col, 16'h1234});
      adv();
      send(1'b1, 8'h12);
      cs_toggle();
      send(1'b1, 8'h34);
      op_q.push_back(CMD_SET_COL);
      send(1'b0, CMD_SET_COL);
      send(1'b1, 8'h02);
      cs_toggle();
      send(1'b1, 8'h03);
      m_cs = 7'd2; m_ce = 7'd3;
      check("cs_hold_op", 32'(cmd_op), 32'h15);

      // Inverted window collapses to a single pixel column/row
      cmd2(CMD_SET_COL, 8'h10, 8'h05);
      cmd2(CMD_SET_ROW, 8'h03, 8'h03);
      ram();
      repeat (3) pixel(16'h07E0);
      check("inv_win_addr", 32'(fb_addr), 32'h0190);

      // Truncated column command
      do_reset();
      op_q.push_back(CMD_WRITE_RAM);
      send(1'b0, CMD_SET_COL);
      send(1'b1, 8'h05);
      send(1'b0, CMD_WRITE_RAM);
      m_col = m_cs; m_row = m_rs;
      check("trunc_err", 32'(proto_err), 32'd1);
      pixel(16'hABCD);
      check("trunc_col", 32'(fb_addr), 32'h0000);

      // Default window: row wrap and full-frame wrap
      do_reset();
      ram();
      for (int i = 0; i < 128; i++) pixel(16'(i) ^ 16'hA5C3);
      check("row_end_addr", 32'(fb_addr), 32'h007F);
      pixel(16'h5555);
      check("row_wrap_addr", 32'(fb_addr), 32'h0080);
      for (int i = 129; i < 128 * 128; i++) pixel(16'(i) ^ 16'h3C96);
      check("frame_last_addr", 32'(fb_addr), 32'h3FFF);
      pixel(16'hFFFF);
      check("frame_wrap_addr", 32'(fb_addr), 32'h0000);

      // Reset after the first byte of a pixel
      ram();
      send(1'b1, 8'h77);
      rst_n = 1'b0;
      bus.oled_cs = 1'b1;
      @(negedge clk);
      check_reset("midpix_reset");
      rst_n = 1'b1;
      send(1'b1, 8'h88);
      send(1'b1, 8'h99);
      repeat (2) @(negedge clk);
      check("post_reset_we", 32'(fb_we), 32'd0);
      check("post_reset_err", 32'(proto_err), 32'd1);

      check("wr_q_drained", 32'(wr_q.size()), 32'd0);
      check("op_q_drained", 32'(op_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
